prog_sequencer: RTL and testbench

//  Program sequencer for the uProcessor control path. Sits directly upstream of the

---
 rtl/uproc_pkg.sv | 29 ++
 rtl/prog_sequencer.sv | 148 ++++++++++++++
 tb/tb_prog_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/uproc_pkg.sv
// Shared uProcessor definitions: ALU codes, ROM control word layout and the
// program sequencer state encoding.
package uproc_pkg;

    localparam logic [2:0] ALU_LDR = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_NOT = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_DEF = 3'd7;

    typedef struct packed {
        logic [3:0] reg_addr;
        logic [2:0] alu_code;
        logic       reg_ce;
        logic       cy_ce;
        logic       a_ce;
        logic       reset_cy;
    } ctrl_word_t;

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_RUN   = 3'd1,
        SEQ_STEP  = 3'd2,
        SEQ_PAUSE = 3'd3,
        SEQ_DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/prog_sequencer.sv
// Program sequencer: drives the control ROM address, handles run/step/pause/
// breakpoint control and gates the ROM enables to executed cycles only.
module prog_sequencer
    import uproc_pkg::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned END_ADDR = 12,
    parameter bit          LOOP     = 1'b0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              step,
    input  logic              halt_req,
    input  logic              brk_en,
    input  logic [ADDR_W-1:0] brk_addr,
    output logic [ADDR_W-1:0] addr,
    input  logic              rom_reg_ce,
    input  logic              rom_cy_ce,
    input  logic              rom_a_ce,
    input  logic              rom_rst_cy,
    output logic              reg_ce,
    output logic              cy_ce,
    output logic              a_ce,
    output logic              reset_cy,
    output logic              running,
    output logic              done,
    output logic [CNT_W-1:0]  instr_cnt
);

    if (END_ADDR >= (1 << ADDR_W)) begin : g_end_addr_check
        $error("prog_sequencer: END_ADDR does not fit in ADDR_W bits");
    end

    localparam logic [ADDR_W-1:0] END_A = ADDR_W'(END_ADDR);
    localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]  ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  MAX_C = {CNT_W{1'b1}};

    seq_state_t        state_r, next_state_s;
    logic [ADDR_W-1:0] addr_r, next_addr_s, addr_inc_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              clr_cnt_s;
    logic              exec_s;

    assign addr_inc_s = addr_r + ONE_A;
    assign exec_s     = ((state_r == SEQ_RUN) || (state_r == SEQ_STEP)) && rst_n;

    // Next-state and program counter decode
    always_comb begin
        next_state_s = state_r;
        next_addr_s  = addr_r;
        clr_cnt_s    = 1'b0;
        case (state_r)
            SEQ_IDLE, SEQ_PAUSE: begin
                if (start) begin
                    next_state_s = SEQ_RUN;
                    clr_cnt_s    = (state_r == SEQ_IDLE);
                end else if (step) begin
                    next_state_s = SEQ_STEP;
                    clr_cnt_s    = (state_r == SEQ_IDLE);
                end else begin
                    next_state_s = state_r;
                end
            end
            SEQ_RUN: begin
                if (addr_r == END_A) begin
                    if (LOOP) begin
                        next_addr_s = ZERO_A;
                    end else begin
                        next_state_s = SEQ_DONE;
                    end
                end else if (halt_req) begin
                    next_addr_s  = addr_inc_s;
                    next_state_s = SEQ_PAUSE;
                end else if (brk_en && (addr_inc_s == brk_addr)) begin
                    // The breakpoint instruction itself is left unexecuted
                    next_addr_s  = addr_inc_s;
                    next_state_s = SEQ_PAUSE;
                end else begin
                    next_addr_s = addr_inc_s;
                end
            end
            SEQ_STEP: begin
                if (addr_r == END_A) begin
                    if (LOOP) begin
                        next_addr_s  = ZERO_A;
                        next_state_s = SEQ_PAUSE;
                    end else begin
                        next_state_s = SEQ_DONE;
                    end
                end else begin
                    next_addr_s  = addr_inc_s;
                    next_state_s = SEQ_PAUSE;
                end
            end
            SEQ_DONE: begin
                if (start) begin
                    next_addr_s  = ZERO_A;
                    next_state_s = SEQ_RUN;
                    clr_cnt_s    = 1'b1;
                end else begin
                    next_state_s = SEQ_DONE;
                end
            end
            default: begin
                next_state_s = SEQ_IDLE;
                next_addr_s  = ZERO_A;
            end
        endcase
    end

    // State, program counter and executed-instruction counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= SEQ_IDLE;
            addr_r  <= ZERO_A;
            cnt_r   <= ZERO_C;
        end else begin
            state_r <= next_state_s;
            addr_r  <= next_addr_s;
            if (clr_cnt_s) begin
                cnt_r <= ZERO_C;
            end else if (exec_s && (cnt_r != MAX_C)) begin
                cnt_r <= cnt_r + ONE_C;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // ROM enables reach the datapath only on executed cycles, never during reset
    always_comb begin
        reg_ce   = rom_reg_ce & exec_s;
        cy_ce    = rom_cy_ce & exec_s;
        a_ce     = rom_a_ce & exec_s;
        reset_cy = rom_rst_cy & exec_s;
    end

    assign addr      = addr_r;
    assign running   = (state_r == SEQ_RUN);
    assign done      = (state_r == SEQ_DONE);
    assign instr_cnt = cnt_r;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: table-driven step/halt vectors plus
// sequences for full run, breakpoint, end-vs-halt, mid-run reset and loop mode.
module tb_prog_sequencer;
    import uproc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, step, halt_req, brk_en, start_l;
    logic [4:0] brk_addr;
    logic [4:0] addr, addr_l;
    logic       reg_ce, cy_ce, a_ce, reset_cy, running, done;
    logic       reg_ce_l, cy_ce_l, a_ce_l, reset_cy_l, running_l, done_l;
    logic [7:0] instr_cnt, instr_cnt_l;
    ctrl_word_t rom_w, rom_wl;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Program ROM enables {reg_ce, cy_ce, a_ce, reset_cy} per address
    function automatic ctrl_word_t rom(input logic [4:0] a);
        logic [3:0] en;
        ctrl_word_t w;
        case (a)
            5'd0:  en = 4'b0011;
            5'd1:  en = 4'b1000;
            5'd2:  en = 4'b0110;
            5'd3:  en = 4'b0010;
            5'd4:  en = 4'b1000;
            5'd5:  en = 4'b1100;
            5'd6:  en = 4'b0010;
            5'd7:  en = 4'b1000;
            5'd8:  en = 4'b1000;
            5'd9:  en = 4'b0010;
            5'd10: en = 4'b1000;
            5'd11: en = 4'b1000;
            5'd12: en = 4'b0010;
            default: en = 4'b0000;
        endcase
        w.reg_addr = a[3:0];
        w.alu_code = ALU_DEF;
        {w.reg_ce, w.cy_ce, w.a_ce, w.reset_cy} = en;
        return w;
    endfunction

    assign rom_w  = rom(addr);
    assign rom_wl = rom(addr_l);

    prog_sequencer #(.ADDR_W(5), .END_ADDR(12), .LOOP(1'b0), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step), .halt_req(halt_req),
        .brk_en(brk_en), .brk_addr(brk_addr), .addr(addr),
        .rom_reg_ce(rom_w.reg_ce), .rom_cy_ce(rom_w.cy_ce), .rom_a_ce(rom_w.a_ce),
        .rom_rst_cy(rom_w.reset_cy), .reg_ce(reg_ce), .cy_ce(cy_ce), .a_ce(a_ce),
        .reset_cy(reset_cy), .running(running), .done(done), .instr_cnt(instr_cnt)
    );

    prog_sequencer #(.ADDR_W(5), .END_ADDR(12), .LOOP(1'b1), .CNT_W(8)) u_loop (
        .clk(clk), .rst_n(rst_n), .start(start_l), .step(1'b0), .halt_req(1'b0),
        .brk_en(1'b0), .brk_addr(5'd0), .addr(addr_l),
        .rom_reg_ce(rom_wl.reg_ce), .rom_cy_ce(rom_wl.cy_ce), .rom_a_ce(rom_wl.a_ce),
        .rom_rst_cy(rom_wl.reset_cy), .reg_ce(reg_ce_l), .cy_ce(cy_ce_l), .a_ce(a_ce_l),
        .reset_cy(reset_cy_l), .running(running_l), .done(done_l), .instr_cnt(instr_cnt_l)
    );

    typedef struct {
        logic       start;
        logic       step;
        logic       halt;
        logic [4:0] exp_addr;
        logic       exp_running;
        logic [7:0] exp_cnt;
        logic [3:0] exp_en;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Advance the main DUT until addr reaches target while running (bounded)
    task automatic run_to(input logic [4:0] target);
        for (int c = 0; c < 20; c++) begin
            if (running && addr == target) break;
            tick();
        end
        check("run_to_reached", {31'd0, running && addr == target}, 32'd1);
    endtask

    vec_t vecs[11];
    int   execs, a_cnt, r_cnt, a_sum;

    initial begin
        rst_n = 1'b0; start = 1'b0; step = 1'b0; halt_req = 1'b0;
        brk_en = 1'b0; brk_addr = 5'd0; start_l = 1'b0;

        // step x3 from IDLE, then resume and halt at addr 4
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'd0, 4'b0000};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0, 4'b0011};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 8'd1, 4'b0000};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 8'd1, 4'b1000};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 5'd2, 1'b0, 8'd2, 4'b0000};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 8'd2, 4'b0110};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 8'd3, 4'b0000};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 8'd3, 4'b0000};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 8'd3, 4'b0010};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 8'd4, 4'b1000};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 8'd5, 4'b0000};

        @(negedge clk);
        do_reset();
        check("reset_addr", {27'd0, addr}, 32'd0);
        check("reset_cnt", {24'd0, instr_cnt}, 32'd0);
        check("reset_flags", {30'd0, running, done}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            start = vecs[i].start; step = vecs[i].step; halt_req = vecs[i].halt;
            #1;
            check($sformatf("row%0d_addr", i), {27'd0, addr}, {27'd0, vecs[i].exp_addr});
            check($sformatf("row%0d_running", i), {31'd0, running}, {31'd0, vecs[i].exp_running});
            check($sformatf("row%0d_cnt", i), {24'd0, instr_cnt}, {24'd0, vecs[i].exp_cnt});
            check($sformatf("row%0d_en", i), {28'd0, reg_ce, cy_ce, a_ce, reset_cy},
                  {28'd0, vecs[i].exp_en});
            tick();
        end
        start = 1'b0; step = 1'b0; halt_req = 1'b0;

        // Full run 0..12, accumulating a small datapath model from the gated enables
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        execs = 0; a_cnt = 0; r_cnt = 0; a_sum = 0;
        for (int c = 0; c < 40; c++) begin
            if (!running) break;
            check($sformatf("run_addr%0d", execs), {27'd0, addr}, execs);
            if (a_ce) begin a_cnt++; a_sum += int'(addr); end
            if (reg_ce) r_cnt++;
            execs++;
            tick();
        end
        check("run_done", {31'd0, done}, 32'd1);
        check("run_end_addr", {27'd0, addr}, 32'd12);
        check("run_cnt", {24'd0, instr_cnt}, 32'd13);
        check("run_execs", execs, 32'd13);
        check("run_a_sum", a_sum, 32'd32);
        check("run_a_cnt", a_cnt, 32'd6);
        check("run_r_cnt", r_cnt, 32'd7);
        step = 1'b1; tick(); step = 1'b0;
        check("done_step_ignored", {31'd0, done}, 32'd1);
        check("done_step_cnt", {24'd0, instr_cnt}, 32'd13);
        check("done_en_off", {28'd0, reg_ce, cy_ce, a_ce, reset_cy}, 32'd0);

        // Breakpoint at 6, then resume executes 6 and runs to the end
        do_reset();
        brk_en = 1'b1; brk_addr = 5'd6;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!running) break;
            tick();
        end
        check("brk_addr", {27'd0, addr}, 32'd6);
        check("brk_cnt", {24'd0, instr_cnt}, 32'd6);
        check("brk_flags", {30'd0, running, done}, 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        check("brk_resume_addr", {27'd0, addr}, 32'd6);
        check("brk_resume_a_ce", {31'd0, a_ce}, 32'd1);
        for (int c = 0; c < 20; c++) begin
            if (done) break;
            tick();
        end
        check("brk_done", {31'd0, done}, 32'd1);
        check("brk_final_cnt", {24'd0, instr_cnt}, 32'd13);
        brk_en = 1'b0;

        // halt_req coinciding with END_ADDR ends the program
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        run_to(5'd12);
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        check("halt_end_done", {31'd0, done}, 32'd1);
        check("halt_end_addr", {27'd0, addr}, 32'd12);

        // Reset asserted mid-run suppresses enables in the same cycle
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        run_to(5'd7);
        check("pre_rst_reg_ce", {31'd0, reg_ce}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_en_off", {28'd0, reg_ce, cy_ce, a_ce, reset_cy}, 32'd0);
        tick();
        rst_n = 1'b1;
        check("rst_addr", {27'd0, addr}, 32'd0);
        check("rst_cnt", {24'd0, instr_cnt}, 32'd0);
        check("rst_flags", {30'd0, running, done}, 32'd0);

        // LOOP=1 instance wraps 12 -> 0 and never finishes
        do_reset();
        start_l = 1'b1; tick(); start_l = 1'b0;
        for (int c = 0; c < 30; c++) begin
            check($sformatf("loop_addr%0d", c), {27'd0, addr_l}, c % 13);
            check($sformatf("loop_flags%0d", c), {30'd0, running_l, done_l}, 32'd2);
            check($sformatf("loop_en%0d", c), {28'd0, reg_ce_l, cy_ce_l, a_ce_l, reset_cy_l},
                  {28'd0, rom(5'(c % 13)).reg_ce, rom(5'(c % 13)).cy_ce,
                   rom(5'(c % 13)).a_ce, rom(5'(c % 13)).reset_cy});
            tick();
        end
        check("loop_cnt", {24'd0, instr_cnt_l}, 32'd30);
        check("loop_addr_end", {27'd0, addr_l}, 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
